// File: rtl/image_src_pkg.sv
// Shared definitions for the image_src frame generator: register map, reset
// defaults, CTRL bit positions, FSM state encoding and config/status bundles.
package image_src_pkg;

    localparam logic [13:0] ADDR_CTRL   = 14'h0000;
    localparam logic [13:0] ADDR_LEN    = 14'h0001;
    localparam logic [13:0] ADDR_SEED   = 14'h0002;
    localparam logic [13:0] ADDR_STATUS = 14'h0003;

    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;

    localparam logic        MODE_RST = 1'b0;
    localparam logic [15:0] LEN_RST  = 16'h0000;
    localparam logic [31:0] SEED_RST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } state_e;

    typedef struct packed {
        logic        mode;
        logic [15:0] len;
        logic [31:0] seed;
    } cfg_t;

    typedef struct packed {
        logic        running;
        logic [15:0] frames_done;
    } status_t;

endpackage

// File: rtl/image_src_regs.sv
// CPU register file for image_src: CTRL/LEN/SEED/STATUS, write ack, read-valid,
// edge-triggered read latch and the START strobe.
module image_src_regs
    import image_src_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_cpu_cs,
    input  logic [31:2] reg_cpu_addr,
    input  logic [31:0] reg_cpu_data_wr,
    output logic [31:0] reg_cpu_data_rd,
    input  logic        reg_cpu_we,
    output logic        reg_cpu_wack,
    input  logic        reg_cpu_re,
    output logic        reg_cpu_rdv,
    input  status_t     status_i,
    output cfg_t        cfg_o,
    output logic        start_o
);

    logic [13:0]   addr;
    logic          wr_en;
    logic          rd_en;
    logic          ctrl_wr;
    logic          unused_addr;

    logic          mode_q;
    logic [15:0]   len_q;
    logic [DW-1:0] seed_q;
    logic          wack_q;
    logic          rdv_q;
    logic          re_q;
    logic [31:0]   rd_q;
    logic [31:0]   rd_d;

    assign addr        = reg_cpu_addr[15:2];
    assign unused_addr = ^reg_cpu_addr[31:16];
    assign wr_en       = reg_cpu_cs & reg_cpu_we;
    assign rd_en       = reg_cpu_cs & reg_cpu_re;
    assign ctrl_wr     = wr_en && (addr == ADDR_CTRL);

    // START is decoded straight off the bus so the FSM leaves IDLE on the
    // same edge that samples the write; MODE travels with it.
    assign start_o    = ctrl_wr & reg_cpu_data_wr[CTRL_START];
    assign cfg_o.mode = ctrl_wr ? reg_cpu_data_wr[CTRL_MODE] : mode_q;
    assign cfg_o.len  = len_q;
    assign cfg_o.seed = 32'(seed_q);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_d = '0;
        case (addr)
            ADDR_CTRL:   rd_d[CTRL_MODE] = mode_q;
            ADDR_LEN:    rd_d[15:0]      = len_q;
            ADDR_SEED:   rd_d            = 32'(seed_q);
            ADDR_STATUS: rd_d            = {status_i.frames_done, 15'd0, status_i.running};
            default:     rd_d            = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_RST;
            len_q  <= LEN_RST;
            seed_q <= SEED_RST[DW-1:0];
            wack_q <= 1'b0;
            rdv_q  <= 1'b0;
            re_q   <= 1'b0;
            rd_q   <= '0;
        end else begin
            wack_q <= wr_en;
            rdv_q  <= rd_en;
            re_q   <= reg_cpu_re;
            if (wr_en) begin
                case (addr)
                    ADDR_CTRL: mode_q <= reg_cpu_data_wr[CTRL_MODE];
                    ADDR_LEN:  len_q  <= reg_cpu_data_wr[15:0];
                    ADDR_SEED: seed_q <= reg_cpu_data_wr[DW-1:0];
                    default:   ;
                endcase
            end
            if (rd_en && !re_q) begin
                rd_q <= rd_d;
            end
        end
    end

    assign reg_cpu_wack    = wack_q;
    assign reg_cpu_rdv     = rdv_q;
    assign reg_cpu_data_rd = rd_q;

endmodule

// File: rtl/image_src.sv
// Image-pipe frame source: streams LEN pixel words (incrementing or constant
// from SEED) with valid/end framing and honours downstream busy.
module image_src
    import image_src_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [DW-1:0] src_data_out,
    output logic          src_valid_out,
    output logic          src_end_out,
    input  logic          src_busy_in,
    input  logic          reg_cpu_cs,
    input  logic [31:2]   reg_cpu_addr,
    input  logic [31:0]   reg_cpu_data_wr,
    output logic [31:0]   reg_cpu_data_rd,
    input  logic          reg_cpu_we,
    output logic          reg_cpu_wack,
    input  logic          reg_cpu_re,
    output logic          reg_cpu_rdv
);

    cfg_t          cfg;
    status_t       status;
    logic          start;
    logic [DW-1:0] word;

    state_e        state_q,  state_d;
    logic [15:0]   idx_q,    idx_d;
    logic [15:0]   len_q,    len_d;
    logic [DW-1:0] seed_q,   seed_d;
    logic          mode_q,   mode_d;
    logic [15:0]   frames_q, frames_d;
    logic [DW-1:0] data_q,   data_d;
    logic          valid_q,  valid_d;
    logic          end_q,    end_d;

    image_src_regs #(.DW(DW)) u_regs (
        .clk             (clk),
        .rst_n           (rst_n),
        .reg_cpu_cs      (reg_cpu_cs),
        .reg_cpu_addr    (reg_cpu_addr),
        .reg_cpu_data_wr (reg_cpu_data_wr),
        .reg_cpu_data_rd (reg_cpu_data_rd),
        .reg_cpu_we      (reg_cpu_we),
        .reg_cpu_wack    (reg_cpu_wack),
        .reg_cpu_re      (reg_cpu_re),
        .reg_cpu_rdv     (reg_cpu_rdv),
        .status_i        (status),
        .cfg_o           (cfg),
        .start_o         (start)
    );

    assign status.running     = (state_q != ST_IDLE);
    assign status.frames_done = frames_q;

    assign word = mode_q ? seed_q : seed_q + DW'(idx_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        seed_d   = seed_q;
        mode_d   = mode_q;
        frames_d = frames_q;
        data_d   = '0;
        valid_d  = 1'b0;
        end_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The frame runs from a shadow copy so later register writes cannot disturb it.
                if (start && (cfg.len != 16'd0)) begin
                    state_d = ST_RUN;
                    idx_d   = 16'd0;
                    len_d   = cfg.len;
                    seed_d  = cfg.seed[DW-1:0];
                    mode_d  = cfg.mode;
                end
            end
            ST_RUN: begin
                if (!src_busy_in) begin
                    valid_d = 1'b1;
                    data_d  = word;
                    idx_d   = idx_q + 16'd1;
                    if (idx_q == len_q - 16'd1) begin
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                if (!src_busy_in) begin
                    end_d    = 1'b1;
                    frames_d = frames_q + 16'd1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the shadow config is reset along with the control state so a mid-frame reset leaves nothing stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            seed_q   <= '0;
            mode_q   <= 1'b0;
            frames_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            seed_q   <= seed_d;
            mode_q   <= mode_d;
            frames_q <= frames_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            end_q    <= end_d;
        end
    end

    assign src_data_out  = data_q;
    assign src_valid_out = valid_q;
    assign src_end_out   = end_q;

endmodule

// File: tb/tb_image_src.sv
// Directed bench for image_src: register vectors, table of busy-free frames,
// and hand sequences for backpressure, END deferral, ignored START and reset.
module tb_image_src;

    localparam logic [29:0] A_CTRL   = 30'h0;
    localparam logic [29:0] A_LEN    = 30'h1;
    localparam logic [29:0] A_SEED   = 30'h2;
    localparam logic [29:0] A_STATUS = 30'h3;

    typedef struct {
        logic [29:0] a;
        logic [31:0] w;
        logic [31:0] r;
        string       name;
    } reg_vec_t;

    typedef struct {
        int          len;
        logic [31:0] seed;
        logic        mode;
        logic [31:0] exp[4];
        logic [31:0] status;
    } frame_vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs, cs8, we, re;
    logic [31:2] addr;
    logic [31:0] wdata;
    logic        busy, busy8;

    logic [31:0] data, rd, rd8;
    logic        valid, eop, wack, rdv;
    logic [7:0]  data8;
    logic        valid8, eop8, wack8, rdv8;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0, vcnt = 0, ecnt = 0, both_cnt = 0;
    int          first_v = -1, last_v = -1, end_c = -1;
    logic [31:0] log_q[$];

    always #5 clk = ~clk;

    image_src #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_data_out(data), .src_valid_out(valid), .src_end_out(eop), .src_busy_in(busy),
        .reg_cpu_cs(cs), .reg_cpu_addr(addr), .reg_cpu_data_wr(wdata), .reg_cpu_data_rd(rd),
        .reg_cpu_we(we), .reg_cpu_wack(wack), .reg_cpu_re(re), .reg_cpu_rdv(rdv)
    );

    image_src #(.DW(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .src_data_out(data8), .src_valid_out(valid8), .src_end_out(eop8), .src_busy_in(busy8),
        .reg_cpu_cs(cs8), .reg_cpu_addr(addr), .reg_cpu_data_wr(wdata), .reg_cpu_data_rd(rd8),
        .reg_cpu_we(we), .reg_cpu_wack(wack8), .reg_cpu_re(re), .reg_cpu_rdv(rdv8)
    );

    // Output monitor for the 32-bit instance, sampled 1 ns after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (valid === 1'b1) begin
            if (vcnt == 0) first_v = cyc;
            last_v = cyc;
            vcnt++;
            log_q.push_back(data);
        end
        if (eop === 1'b1) begin
            ecnt++;
            end_c = cyc;
            if (valid === 1'b1) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        vcnt = 0; ecnt = 0; both_cnt = 0;
        first_v = -1; last_v = -1; end_c = -1;
        log_q.delete();
    endtask

    task automatic bus_write(input int sel, input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = (sel == 0); cs8 = (sel != 0); we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        check("wack", (sel == 0) ? wack : wack8, 1);
        cs = 1'b0; cs8 = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input int sel, input logic [29:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = (sel == 0); cs8 = (sel != 0); re = 1'b1; addr = a;
        @(negedge clk);
        check("rdv", (sel == 0) ? rdv : rdv8, 1);
        d = (sel == 0) ? rd : rd8;
        cs = 1'b0; cs8 = 1'b0; re = 1'b0;
    endtask

    task automatic read_check(input int sel, input logic [29:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        bus_read(sel, a, v);
        check(name, v, exp);
    endtask

    task automatic check_frame(input string tag, input int len, input int s, input int span,
                               input int end_gap, input logic [31:0] e[4]);
        check({tag, "_vcnt"}, vcnt, len);
        check({tag, "_ecnt"}, ecnt, 1);
        check({tag, "_first"}, first_v, s + 1);
        check({tag, "_span"}, last_v - first_v, span);
        check({tag, "_endgap"}, end_c - last_v, end_gap);
        check({tag, "_overlap"}, both_cnt, 0);
        for (int k = 0; k < len && k < log_q.size(); k++)
            check($sformatf("%s_data%0d", tag, k), log_q[k], e[k]);
    endtask

    task automatic set_fv(output frame_vec_t f, input int len, input logic [31:0] seed, input logic mode,
                          input logic [31:0] e0, e1, e2, e3, input logic [31:0] st);
        f.len = len; f.seed = seed; f.mode = mode;
        f.exp[0] = e0; f.exp[1] = e1; f.exp[2] = e2; f.exp[3] = e3;
        f.status = st;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_vec_t    rv[8];
        frame_vec_t  fv[4];
        logic [31:0] e[4];
        logic [31:0] v;
        logic        exp_v8[4];
        logic [7:0]  exp_d8[4];
        logic        exp_e8[4];
        int          s;

        cs = 0; cs8 = 0; we = 0; re = 0; addr = '0; wdata = '0;
        busy = 0; busy8 = 0; rst_n = 0;

        rv[0] = '{A_LEN,    32'hABCD_5678, 32'h0000_5678, "reg_len"};
        rv[1] = '{A_SEED,   32'hDEAD_BEEF, 32'hDEAD_BEEF, "reg_seed"};
        rv[2] = '{A_CTRL,   32'hFFFF_FFFE, 32'h0000_0002, "reg_ctrl_mode"};
        rv[3] = '{A_CTRL,   32'h0000_0000, 32'h0000_0000, "reg_ctrl_clr"};
        rv[4] = '{A_STATUS, 32'hFFFF_FFFF, 32'h0000_0000, "reg_status_ro"};
        rv[5] = '{30'h5,    32'h1234_5678, 32'h0000_0000, "reg_unmapped"};
        rv[6] = '{30'h4001, 32'h0000_0042, 32'h0000_0042, "reg_alias_len"};
        rv[7] = '{30'h2001, 32'h0000_0099, 32'h0000_0000, "reg_hi_unmapped"};

        set_fv(fv[0], 4, 32'h10,        1'b0, 32'h10, 32'h11, 32'h12, 32'h13, 32'h0001_0000);
        set_fv(fv[1], 3, 32'hAB,        1'b1, 32'hAB, 32'hAB, 32'hAB, 32'h0,  32'h0002_0000);
        set_fv(fv[2], 2, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0003_0000);
        set_fv(fv[3], 1, 32'h5,         1'b0, 32'h5,  32'h0,  32'h0,  32'h0,  32'h0004_0000);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_end", eop, 0);
        check("rst_wack", wack, 0);
        check("rst_rdv", rdv, 0);
        check("rst_rd", rd, 0);
        check("rst_valid8", valid8, 0);
        rst_n = 1;

        // Register access vectors
        for (int i = 0; i < 8; i++) begin
            bus_write(0, rv[i].a, rv[i].w);
            read_check(0, rv[i].a, rv[i].r, rv[i].name);
        end
        read_check(0, A_LEN, 32'h42, "len_after_unmapped");

        // Busy-free frames
        for (int i = 0; i < 4; i++) begin
            bus_write(0, A_LEN, 32'(fv[i].len));
            bus_write(0, A_SEED, fv[i].seed);
            bus_write(0, A_CTRL, {30'h0, fv[i].mode, 1'b0});
            clear_mon();
            bus_write(0, A_CTRL, {30'h0, fv[i].mode, 1'b1});
            s = cyc;
            repeat (fv[i].len + 4) @(negedge clk);
            check_frame($sformatf("frame%0d", i), fv[i].len, s, fv[i].len - 1, 1, fv[i].exp);
            read_check(0, A_STATUS, fv[i].status, $sformatf("frame%0d_status", i));
        end

        // Busy for 3 edges after word1: no skipped or duplicated index
        bus_write(0, A_LEN, 32'd4);
        bus_write(0, A_SEED, 32'h10);
        bus_write(0, A_CTRL, 32'h0);
        clear_mon();
        bus_write(0, A_CTRL, 32'h1);
        s = cyc;
        repeat (2) @(negedge clk);
        busy = 1;
        repeat (3) @(negedge clk);
        busy = 0;
        repeat (6) @(negedge clk);
        e = '{32'h10, 32'h11, 32'h12, 32'h13};
        check_frame("busy", 4, s, 6, 1, e);
        read_check(0, A_STATUS, 32'h0005_0000, "busy_status");

        // Busy while in END defers a still single-cycle end pulse
        bus_write(0, A_LEN, 32'd2);
        bus_write(0, A_SEED, 32'h77);
        clear_mon();
        bus_write(0, A_CTRL, 32'h1);
        s = cyc;
        repeat (2) @(negedge clk);
        busy = 1;
        read_check(0, A_STATUS, 32'h0005_0001, "end_running");
        busy = 0;
        repeat (4) @(negedge clk);
        e = '{32'h77, 32'h78, 32'h0, 32'h0};
        check_frame("enddefer", 2, s, 1, 3, e);
        read_check(0, A_STATUS, 32'h0006_0000, "enddefer_status");

        // START with LEN = 0 is ignored
        bus_write(0, A_LEN, 32'd0);
        clear_mon();
        bus_write(0, A_CTRL, 32'h1);
        read_check(0, A_STATUS, 32'h0006_0000, "len0_status");
        repeat (4) @(negedge clk);
        check("len0_vcnt", vcnt, 0);
        check("len0_ecnt", ecnt, 0);

        // START and LEN writes during a frame do not alter it
        bus_write(0, A_LEN, 32'd3);
        bus_write(0, A_SEED, 32'h20);
        clear_mon();
        bus_write(0, A_CTRL, 32'h1);
        s = cyc;
        bus_write(0, A_CTRL, 32'h1);
        bus_write(0, A_LEN, 32'd6);
        repeat (6) @(negedge clk);
        e = '{32'h20, 32'h21, 32'h22, 32'h0};
        check_frame("restart", 3, s, 2, 1, e);
        read_check(0, A_STATUS, 32'h0007_0000, "restart_status");
        read_check(0, A_LEN, 32'd6, "restart_len");

        // DW = 8 wrap-around
        bus_write(1, A_LEN, 32'd3);
        bus_write(1, A_SEED, 32'h1234_56FE);
        read_check(1, A_SEED, 32'h0000_00FE, "dw8_seed");
        bus_write(1, A_CTRL, 32'h0);
        bus_write(1, A_CTRL, 32'h1);
        exp_v8 = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_d8 = '{8'hFE, 8'hFF, 8'h00, 8'h00};
        exp_e8 = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("dw8_valid%0d", k), valid8, exp_v8[k]);
            check($sformatf("dw8_data%0d", k), data8, exp_d8[k]);
            check($sformatf("dw8_end%0d", k), eop8, exp_e8[k]);
        end
        read_check(1, A_STATUS, 32'h0001_0000, "dw8_status");

        // Reset at word2 of an 8-word frame
        bus_write(0, A_LEN, 32'd8);
        bus_write(0, A_SEED, 32'h40);
        clear_mon();
        bus_write(0, A_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_end", eop, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("mid_rst_vcnt", vcnt, 2);
        check("mid_rst_ecnt", ecnt, 0);
        read_check(0, A_LEN, 32'h0, "mid_rst_len");
        read_check(0, A_SEED, 32'h0, "mid_rst_seed");
        read_check(0, A_STATUS, 32'h0, "mid_rst_status");
        read_check(0, A_CTRL, 32'h0, "mid_rst_ctrl");
        bus_read(0, A_LEN, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
